// File: rtl/uart_pkg.sv
// Shared constants, state encodings and parity helper
// for the parametrised UART transceiver.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    // Word is zero-extended by the caller, so unused MSBs do not disturb the XOR.
    function automatic logic calc_parity(input logic [8:0] word, input int mode);
        logic p;
        p = ^word;
        if (mode == PAR_ODD) return ~p;
        if (mode == PAR_EVEN) return p;
        return 1'b0;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM,
// parity/framing checks and break (held-low line) suppression.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [8:0]           shift_ext;
    logic                 line;
    logic                 bit_end;

    assign line    = sync2_q;
    assign bit_end = (cnt_q == BIT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        par_d     = par_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        shift_ext = '0;
        shift_ext[DATA_BITS-1:0] = shift_q;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!line) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = line ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST)
                        state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    else
                        bit_d = bit_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    par_d   = line;
                    state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    perr_d  = (PARITY != PAR_NONE) &&
                              (par_q != calc_parity(shift_ext, PARITY));
                    ferr_d  = !line;
                    state_d = line ? RX_IDLE : RX_BREAK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_BREAK: begin
                if (line) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;

endmodule

// File: rtl/uart_param_transceiver.sv
// Full-duplex UART with configurable timing, width, parity and stop bits.
// TX FSM lives here; the receiver is in uart_rx_core.
module uart_param_transceiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 serial_out,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int TCW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam logic [TCW-1:0] BIT_LAST  = TCW'(CLKS_PER_BIT - 1);
    localparam logic [TCW-1:0] STOP_LAST = TCW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [TCW-1:0]       cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [8:0]           data_ext;
    logic                 bit_end;
    logic                 accept;

    assign bit_end = (cnt_q == BIT_LAST);
    assign tx_done = (state_q == TX_STOP) && (cnt_q == STOP_LAST);
    assign tx_busy = (state_q != TX_IDLE) && !tx_done;
    // Accepting in the final stop cycle lets frames run back-to-back.
    assign accept  = tx_start && !tx_busy;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        data_ext = '0;
        data_ext[DATA_BITS-1:0] = tx_data;
        unique case (state_q)
            TX_IDLE: cnt_d = '0;
            TX_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q + TCW'(1);
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST)
                        state_d = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                    else
                        bit_d = bit_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + TCW'(1);
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = TX_STOP;
                end else begin
                    cnt_d = cnt_q + TCW'(1);
                end
            end
            TX_STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + TCW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
        if (accept) begin
            state_d = TX_START;
            cnt_d   = '0;
            shift_d = tx_data;
            par_d   = calc_parity(data_ext, PARITY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    // Decoded from state so an asynchronous reset idles the line at once.
    always_comb begin
        serial_out = 1'b1;
        unique case (state_q)
            TX_START:  serial_out = 1'b0;
            TX_DATA:   serial_out = shift_q[0];
            TX_PARITY: serial_out = par_q;
            default:   serial_out = 1'b1;
        endcase
    end

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY       (PARITY)
    ) u_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .serial_in     (serial_in),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err)
    );

endmodule
